// File: rtl/dbg_bus_master.sv
// Host-command to debug-bus initiator: one debug-port transaction per accepted command,
// with per-phase timeout and a valid/ready response channel.
module dbg_bus_master #(
    parameter int DBG_ADDR_WIDTH = 15,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [DBG_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      debug_req_o,
    input  logic                      debug_gnt_i,
    input  logic                      debug_rvalid_i,
    output logic [DBG_ADDR_WIDTH-1:0] debug_addr_o,
    output logic                      debug_we_o,
    output logic [31:0]               debug_wdata_o,
    input  logic [31:0]               debug_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] count;
    logic [15:0] count_inc;
    logic        timeout;

    // The counter saturates so an out-of-range limit can never cause a wrap.
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
    assign timeout   = (count >= LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            debug_req_o   <= 1'b0;
            debug_we_o    <= 1'b0;
            debug_addr_o  <= '0;
            debug_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        debug_we_o    <= cmd_we_i;
                        debug_addr_o  <= cmd_addr_i;
                        debug_wdata_o <= cmd_wdata_i;
                        debug_req_o   <= 1'b1;
                        cmd_ready_o   <= 1'b0;
                        count         <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // A grant in the final allowed cycle still beats the timeout.
                    if (debug_gnt_i) begin
                        debug_req_o <= 1'b0;
                        count       <= '0;
                        state       <= WAIT;
                    end else if (timeout) begin
                        debug_req_o <= 1'b0;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        count <= count_inc;
                    end
                end
                WAIT: begin
                    if (debug_rvalid_i) begin
                        rsp_rdata_o <= debug_we_o ? 32'h0 : debug_rdata_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (timeout) begin
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        count <= count_inc;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master: the bench plays the core side and queues
// expected responses when each command is issued.
module tb_dbg_bus_master;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [14:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        debug_req_o;
    logic        debug_gnt_i;
    logic        debug_rvalid_i;
    logic [14:0] debug_addr_o;
    logic        debug_we_o;
    logic [31:0] debug_wdata_o;
    logic [31:0] debug_rdata_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    dbg_bus_master #(.DBG_ADDR_WIDTH(15), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i),
        .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o),
        .debug_wdata_o(debug_wdata_o), .debug_rdata_i(debug_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drives one command and plays the core with the given grant/rvalid delays
    // (negative delay = never). rspDelay cycles of response backpressure also
    // hold a second command on the channel to prove it is not taken early.
    task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [31:0] wdata,
                                 input int gntDelay, input int rvDelay, input logic [31:0] coreRdata,
                                 input int rspDelay, input string tag);
        int   reqCycles;
        int   waitCycles;
        logic gntTo;
        logic rvTo;
        rsp_t exp;
        rsp_t got;
        gntTo = (gntDelay < 0) || (gntDelay >= TO);
        rvTo  = !gntTo && ((rvDelay < 0) || (rvDelay >= TO));
        exp.err   = gntTo || rvTo;
        exp.rdata = (exp.err || we) ? 32'h0 : coreRdata;
        checkOutput({tag, "_cmdReadyIdle"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        expQ.push_back(exp);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 15'h1555;
        cmd_wdata_i = 32'hA5A5A5A5;
        cmd_we_i    = ~we;
        reqCycles = 0;
        while (debug_req_o && reqCycles < 100) begin
            checkOutput({tag, "_addr"}, 32'(debug_addr_o), 32'(addr));
            checkOutput({tag, "_we"}, 32'(debug_we_o), 32'(we));
            checkOutput({tag, "_wdata"}, debug_wdata_o, wdata);
            debug_gnt_i = (reqCycles == gntDelay);
            @(negedge clk_i);
            debug_gnt_i = 1'b0;
            reqCycles++;
        end
        checkOutput({tag, "_reqCycles"}, 32'(reqCycles), gntTo ? 32'(TO) : 32'(gntDelay + 1));
        waitCycles = 0;
        while (!rsp_valid_o && waitCycles < TO + 4) begin
            debug_rvalid_i = (waitCycles == rvDelay);
            debug_rdata_i  = (waitCycles == rvDelay) ? coreRdata : 32'hBADBAD00;
            @(negedge clk_i);
            debug_rvalid_i = 1'b0;
            debug_rdata_i  = 32'h0;
            waitCycles++;
        end
        if (!gntTo)
            checkOutput({tag, "_waitCycles"}, 32'(waitCycles), rvTo ? 32'(TO) : 32'(rvDelay + 1));
        checkOutput({tag, "_rspValid"}, 32'(rsp_valid_o), 32'd1);
        got = expQ.pop_front();
        checkOutput({tag, "_rdata"}, rsp_rdata_o, got.rdata);
        checkOutput({tag, "_err"}, 32'(rsp_err_o), 32'(got.err));
        for (int i = 0; i < rspDelay; i++) begin
            cmd_valid_i = 1'b1;
            @(negedge clk_i);
            checkOutput({tag, "_bpValid"}, 32'(rsp_valid_o), 32'd1);
            checkOutput({tag, "_bpRdata"}, rsp_rdata_o, got.rdata);
            checkOutput({tag, "_bpErr"}, 32'(rsp_err_o), 32'(got.err));
            checkOutput({tag, "_bpCmdReady"}, 32'(cmd_ready_o), 32'd0);
            checkOutput({tag, "_bpNoReq"}, 32'(debug_req_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        checkOutput({tag, "_rspDone"}, 32'(rsp_valid_o), 32'd0);
        checkOutput({tag, "_cmdReadyBack"}, 32'(cmd_ready_o), 32'd1);
        checkOutput({tag, "_noEarlyReq"}, 32'(debug_req_o), 32'd0);
    endtask

    // Stray core handshakes while idle must not start anything or make a response.
    task automatic strayInIdle(input string tag);
        for (int i = 0; i < 4; i++) begin
            debug_rvalid_i = 1'b1;
            debug_gnt_i    = i[0];
            debug_rdata_i  = 32'h5757_0000 + 32'(i);
            rsp_ready_i    = 1'b1;
            @(negedge clk_i);
            checkOutput({tag, "_noRsp"}, 32'(rsp_valid_o), 32'd0);
            checkOutput({tag, "_noReq"}, 32'(debug_req_o), 32'd0);
            checkOutput({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
        end
        debug_rvalid_i = 1'b0;
        debug_gnt_i    = 1'b0;
        debug_rdata_i  = 32'h0;
        rsp_ready_i    = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        cmd_valid_i    = 1'b0;
        cmd_we_i       = 1'b0;
        cmd_addr_i     = '0;
        cmd_wdata_i    = '0;
        rsp_ready_i    = 1'b0;
        debug_gnt_i    = 1'b0;
        debug_rvalid_i = 1'b0;
        debug_rdata_i  = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_cmdReady", 32'(cmd_ready_o), 32'd1);
        checkOutput("rst_rspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rst_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rst_req", 32'(debug_req_o), 32'd0);
        checkOutput("rst_we", 32'(debug_we_o), 32'd0);
        checkOutput("rst_addr", 32'(debug_addr_o), 32'd0);
        checkOutput("rst_wdata", debug_wdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        applyStimulus(1'b0, 15'h2000, 32'h0, 0, 0, 32'hDEADBEEF, 0, "rdNominal");
        applyStimulus(1'b1, 15'h0004, 32'h00010000, 5, 0, 32'h12345678, 0, "wrStall");
        applyStimulus(1'b0, 15'h0010, 32'h0, -1, 0, 32'hCAFEF00D, 0, "gntTimeout");
        applyStimulus(1'b0, 15'h0011, 32'h0, 0, 2, 32'h600DF00D, 0, "afterGntTo");
        applyStimulus(1'b0, 15'h0123, 32'h0, TO - 1, TO - 1, 32'h0BADCAFE, 0, "lastCycleWins");
        applyStimulus(1'b0, 15'h0200, 32'h0, 1, -1, 32'h11111111, 0, "rvTimeout");
        strayInIdle("strayIdle");
        applyStimulus(1'b0, 15'h7ABC, 32'h0, 0, 0, 32'h87654321, 10, "backpressure");
        applyStimulus(1'b1, 15'h0ACE, 32'hFEEDFACE, 0, 0, 32'h99999999, 0, "afterBp");

        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 15'h0333;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checkOutput("midRst_inReq", 32'(debug_req_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("midRst_req", 32'(debug_req_o), 32'd0);
        checkOutput("midRst_cmdReady", 32'(cmd_ready_o), 32'd1);
        checkOutput("midRst_rspValid", 32'(rsp_valid_o), 32'd0);
        strayInIdle("midRstQuiet");
        applyStimulus(1'b0, 15'h0444, 32'h0, 0, 0, 32'h13579BDF, 0, "afterRst");

        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dbg_bus_master.md
Name: dbg_bus_master

Overview:
- Initiator for the core's debug-unit slave port. Drives debug_req/addr/we/wdata and consumes debug_gnt/rvalid/rdata.
- Converts single commands from a host-side valid/ready command channel (testbench, JTAG bridge or Verilator harness) into one debug-bus transaction each.
- Returns read data and error status on a valid/ready response channel.
- Sits beside the core wrapper. Its debug_* outputs connect directly to the core's debug_* inputs.

Parameters:
- DBG_ADDR_WIDTH, 15, debug address width; matches the core's debug_addr_i.
- TIMEOUT_CYCLES, 255, maximum cycles allowed in each of REQ and WAIT before abort; legal range 1..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  DBG_ADDR_WIDTH  debug register address
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  host accepts response
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_err_o  out  1  transaction timed out
- debug_req_o  out  1  bus request
- debug_gnt_i  in  1  grant from core
- debug_rvalid_i  in  1  response valid from core
- debug_addr_o  out  DBG_ADDR_WIDTH  bus address
- debug_we_o  out  1  bus write enable
- debug_wdata_o  out  32  bus write data
- debug_rdata_i  in  32  bus read data

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high (rst_i).
- Reset values: state=IDLE; cmd_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; debug_req_o=0; debug_we_o=0; debug_addr_o=0; debug_wdata_o=0; timeout counter=0.
- Reset mid-transaction: abandons the transaction. debug_req_o is 0 from the first edge with rst_i=1, and no response is produced.
- All outputs are registered. State machine has four states:
  - IDLE: cmd_ready_o=1. On cmd_valid_i&&cmd_ready_o, capture we/addr/wdata into the debug_* output registers, set debug_req_o=1, clear the counter, go to REQ. debug_req_o is therefore first high the cycle after acceptance.
  - REQ: debug_req_o=1; addr/we/wdata held stable.
    - debug_gnt_i=1: drop debug_req_o at that edge, clear the counter, go to WAIT.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no grant: drop req, set rsp_err_o=1, rsp_rdata_o=0, go to RESP.
  - WAIT: debug_req_o=0.
    - debug_rvalid_i=1: rsp_rdata_o = debug_rdata_i for reads, 0 for writes; rsp_err_o=0; go to RESP.
    - Otherwise increment the counter; timeout as in REQ (err=1, rdata=0, go to RESP).
    - rvalid in the first WAIT cycle (one cycle after gnt) is the nominal core latency. Any later rvalid is also accepted.
  - RESP: rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable. On rsp_ready_i, rsp_valid_o falls and the state goes to IDLE.
- cmd_ready_o is 1 only in IDLE.
  - Minimum command-to-command spacing (gnt and rvalid each on first opportunity, rsp_ready_i tied 1) is 4 cycles: accept, REQ, WAIT, RESP.
  - No pipelining: only one outstanding transaction.
- debug_rvalid_i or debug_gnt_i arriving in IDLE, RESP, or in the same cycle the state is entered is ignored. For REQ, only gnt is sampled; for WAIT, only rvalid is sampled.
- gnt during REQ and a timeout in the same cycle: grant wins and there is no error.
- Counter width is 16 bits; it saturates and never wraps.
- rsp_rdata_o and rsp_err_o change only on entry to RESP.

Test Plan:
- Read, nominal: cmd read addr 0x2000; core gnt on first REQ cycle, rvalid next cycle with rdata 0xDEADBEEF → rsp_valid_o=1 with rsp_rdata_o=0xDEADBEEF, rsp_err_o=0; debug_req_o high exactly 1 cycle; debug_addr_o=0x2000, debug_we_o=0.
- Write with stalled grant: cmd write addr 0x0004, wdata 0x00010000; gnt withheld 5 cycles → debug_req_o high 6 cycles with addr/wdata/we=1 stable; after rvalid, rsp_rdata_o=0, rsp_err_o=0.
- Grant timeout: TIMEOUT_CYCLES=8, gnt never asserted → debug_req_o falls after 8 REQ cycles; rsp_err_o=1, rsp_rdata_o=0; next command accepted normally.
- rvalid timeout and stray signals: gnt given, rvalid never arrives → err response after TIMEOUT_CYCLES WAIT cycles. Stray rvalid pulses in IDLE → no state change, no response.
- Response backpressure: rsp_ready_i held 0 for 10 cycles → rsp_valid_o and data stable throughout; cmd_ready_o=0; cmd_valid_i held high is not accepted until one cycle after the rsp handshake.
- Reset mid-operation: rst_i=1 during REQ → debug_req_o=0, cmd_ready_o=1, rsp_valid_o=0 after that edge; no response emitted; subsequent read completes correctly.
